// File: rtl/seq_pkg.sv
// seq_pkg: constants and types shared by the pattern transmitter and the 1101 detector blocks.
package seq_pkg;
  localparam int TARGET_LEN = 4;
  localparam logic [TARGET_LEN-1:0] TARGET = 4'b1101;
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} tx_state_t;
endpackage

// File: rtl/seq_pattern_tx_if.sv
// seq_pattern_tx_if: word handshake, serial stream and matcher signals of seq_pattern_tx.
interface seq_pattern_tx_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             data_valid;
  logic [WIDTH-1:0] data_in;
  logic             data_ready;
  logic             x_out;
  logic             x_valid;
  logic             busy;
  logic             hit;
  logic [CNT_W-1:0] hit_count;
  logic             hit_clr;
  modport master (
    output data_valid, data_in, hit_clr,
    input  data_ready, x_out, x_valid, busy, hit, hit_count
  );
  modport slave (
    input  data_valid, data_in, hit_clr,
    output data_ready, x_out, x_valid, busy, hit, hit_count
  );
endinterface

// File: rtl/seq_match.sv
// seq_match: overlapping TARGET matcher over a qualified bit stream with a saturating hit counter.
module seq_match
  import seq_pkg::*;
#(
  parameter logic [TARGET_LEN-1:0] TARGET = seq_pkg::TARGET,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clr,
  output logic             hit,
  output logic [CNT_W-1:0] hit_count
);
  logic [TARGET_LEN-2:0] history;
  assign hit = bit_valid && ({history, bit_in} == TARGET);
  // history only advances on stream bits, so matches survive idle gaps
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      history   <= '0;
      hit_count <= '0;
    end else if (clr) begin
      history   <= '0;
      hit_count <= '0;
    end else begin
      if (bit_valid) history <= {history[TARGET_LEN-3:0], bit_in};
      if (hit && !(&hit_count)) hit_count <= hit_count + 1'b1;
    end
endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: MSB-first word serializer with a built-in TARGET hit counter.
// Defining SEQ_TX_PARITY_EN appends one even-parity bit after each word.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [TARGET_LEN-1:0] TARGET = seq_pkg::TARGET,
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             reset,
  seq_pattern_tx_if.slave bus
);
  localparam int BW = $clog2(WIDTH);
  tx_state_t        state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic             last;
  logic             accept;
  logic             hit;
  logic [CNT_W-1:0] hit_count;
  assign last = (state == SHIFT) && (bit_cnt == '0);
`ifdef SEQ_TX_PARITY_EN
  logic par;
  localparam tx_state_t AFTER_LAST = PAR;
  assign bus.data_ready = (state == IDLE) || (state == PAR);
  assign bus.x_out      = (state == SHIFT) ? shreg[WIDTH-1] : (state == PAR) && par;
`else
  localparam tx_state_t AFTER_LAST = IDLE;
  assign bus.data_ready = (state == IDLE) || last;
  assign bus.x_out      = (state == SHIFT) && shreg[WIDTH-1];
`endif
  assign bus.x_valid   = state != IDLE;
  assign bus.busy      = state != IDLE;
  assign bus.hit       = hit;
  assign bus.hit_count = hit_count;
  assign accept        = bus.data_valid && bus.data_ready;
  // a reload on the final bit takes priority, giving zero-bubble back-to-back words
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
`ifdef SEQ_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else if (accept) begin
      state   <= SHIFT;
      shreg   <= bus.data_in;
      bit_cnt <= BW'(WIDTH - 1);
`ifdef SEQ_TX_PARITY_EN
      par     <= ^bus.data_in;
`endif
    end else if (state == SHIFT) begin
      shreg   <= shreg << 1;
      bit_cnt <= bit_cnt - 1'b1;
      if (last) state <= AFTER_LAST;
`ifdef SEQ_TX_PARITY_EN
    end else if (state == PAR) begin
      state <= IDLE;
`endif
    end
  seq_match #(.TARGET(TARGET), .CNT_W(CNT_W)) u_match (
    .clk       (clk),
    .reset     (reset),
    .bit_in    (bus.x_out),
    .bit_valid (bus.x_valid),
    .clr       (bus.hit_clr),
    .hit       (hit),
    .hit_count (hit_count)
  );
endmodule
